// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle sync IRAM, and buffers {pc,inst} in a queue for ID.
// Optional IF_PERF_CNT_EN adds fetch and bubble performance counters.
module if_fetch_queue #(
  parameter int          IRAM_AW  = 12,
  parameter int          QDEPTH   = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_start,
  input  logic [29:0]        start_adr,
  input  logic               trap_ex,
  input  logic [29:0]        csr_mtvec_ex,
  input  logic               jmp_condition_ex,
  input  logic [29:0]        jmp_adr_ex,
  input  logic               cmd_mret_ex,
  input  logic [29:0]        csr_mepc_ex,
  input  logic               cmd_sret_ex,
  input  logic [29:0]        csr_sepc_ex,
  input  logic               cmd_uret_ex,
  output logic               iram_ren,
  output logic [IRAM_AW-1:0] iram_radr,
  input  logic [31:0]        iram_rdata,
  input  logic               i_read_sel,
  output logic               inst_valid_id,
  input  logic               inst_ready_id,
  output logic [31:0]        inst_id,
  output logic [29:0]        pc_id,
  output logic               post_jump_cmd_cond,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt,
`endif
  output logic [31:0]        pc_data
);
  localparam int PW = $clog2(QDEPTH);

  // Handshake: an entry moves to ID in any cycle where inst_valid_id and inst_ready_id are both high;
  // inst_id/pc_id are held stable while valid and not ready.
  logic [29:0]   pc_if_q, pc_if_d;
  logic          running_q, running_d;
  logic          inflight_q;
  logic [29:0]   inflight_pc_q;
  logic          post_trap_q;
  logic          post_jump_q;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [29:0]   mem_pc_q   [QDEPTH];
  logic [31:0]   mem_inst_q [QDEPTH];

  logic          ret_jmp;
  logic          redirect;
  logic [29:0]   target;
  logic [PW+1:0] occupancy;
  logic          issue, push, pop;

  always_comb begin
    ret_jmp  = (cmd_mret_ex | cmd_sret_ex | cmd_uret_ex | jmp_condition_ex) & ~post_trap_q;
    redirect = cpu_start | trap_ex | ret_jmp;
    target   = jmp_adr_ex;
    if (cpu_start)                       target = start_adr;
    else if (trap_ex)                    target = csr_mtvec_ex;
    else if (cmd_mret_ex & ~post_trap_q) target = csr_mepc_ex;
    else if (cmd_sret_ex & ~post_trap_q) target = csr_sepc_ex;
    occupancy = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
    issue     = running_q & ~i_read_sel & ~redirect & (occupancy < (PW+2)'(QDEPTH));
    push      = inflight_q & ~redirect;
    pop       = (count_q != '0) & inst_ready_id;
  end

  always_comb begin
    running_d = running_q | cpu_start;
    pc_if_d   = pc_if_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (redirect) begin
      // A flush drops every queued entry and the returning read in one step.
      pc_if_d  = target;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (issue) pc_if_d  = pc_if_q + 30'd1;
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if_q       <= RESET_PC;
      running_q     <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      post_trap_q   <= 1'b0;
      post_jump_q   <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      pc_if_q     <= pc_if_d;
      running_q   <= running_d;
      inflight_q  <= issue;
      post_trap_q <= trap_ex;
      post_jump_q <= ret_jmp;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (issue) inflight_pc_q <= pc_if_q;
      if (push) begin
        mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
        mem_inst_q[wr_ptr_q] <= iram_rdata;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (push)                          fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (running_q && count_q == '0)    bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end
  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

  assign iram_ren           = issue;
  assign iram_radr          = pc_if_q[IRAM_AW-1:0];
  assign inst_valid_id      = (count_q != '0);
  assign inst_id            = mem_inst_q[rd_ptr_q];
  assign pc_id              = mem_pc_q[rd_ptr_q];
  assign post_jump_cmd_cond = post_jump_q;
  assign pc_data            = {pc_if_q, 2'b00};
endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: directed and random redirect/stall traffic against a PC-sequence scoreboard.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_start = 0, trap_ex = 0, jmp_condition_ex = 0;
  logic        cmd_mret_ex = 0, cmd_sret_ex = 0, cmd_uret_ex = 0;
  logic [29:0] start_adr = 0, csr_mtvec_ex = 0, jmp_adr_ex = 0, csr_mepc_ex = 0, csr_sepc_ex = 0;
  logic        iram_ren;
  logic [11:0] iram_radr;
  logic [31:0] iram_rdata;
  logic        i_read_sel = 0;
  logic        inst_valid_id;
  logic        inst_ready_id = 0;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        post_jump_cmd_cond;
  logic [31:0] pc_data;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  if_fetch_queue #(.IRAM_AW(12), .QDEPTH(4), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .start_adr(start_adr),
    .trap_ex(trap_ex), .csr_mtvec_ex(csr_mtvec_ex), .jmp_condition_ex(jmp_condition_ex),
    .jmp_adr_ex(jmp_adr_ex), .cmd_mret_ex(cmd_mret_ex), .csr_mepc_ex(csr_mepc_ex),
    .cmd_sret_ex(cmd_sret_ex), .csr_sepc_ex(csr_sepc_ex), .cmd_uret_ex(cmd_uret_ex),
    .iram_ren(iram_ren), .iram_radr(iram_radr), .iram_rdata(iram_rdata),
    .i_read_sel(i_read_sel), .inst_valid_id(inst_valid_id), .inst_ready_id(inst_ready_id),
    .inst_id(inst_id), .pc_id(pc_id), .post_jump_cmd_cond(post_jump_cmd_cond),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .pc_data(pc_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [11:0] a);
    return {a, 4'h5, ~a, 4'hA};
  endfunction

  // synchronous IRAM model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) iram_rdata <= '0;
    else if (iram_ren) iram_rdata <= mem_f(iram_radr);
  end

  int checks = 0;
  int fails  = 0;

  // reference model state
  logic [29:0] exp_pc;
  logic        running_m, post_trap_m, post_jump_m, red_prev, stall_prev, prev_ren;
  logic [29:0] tgt_prev, prev_pc_id;
  logic [31:0] prev_inst;
  logic [31:0] fetch_m, bubble_m;
  logic [29:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    running_m = 0; post_trap_m = 0; post_jump_m = 0; red_prev = 0; stall_prev = 0;
    prev_ren = 0; tgt_prev = 0; prev_pc_id = 0; prev_inst = 0; fetch_m = 0; bubble_m = 0;
    exp_pc = 0;
  endtask

  task automatic clear_cmds();
    cpu_start = 0; trap_ex = 0; jmp_condition_ex = 0;
    cmd_mret_ex = 0; cmd_sret_ex = 0; cmd_uret_ex = 0;
  endtask

  // one clock: check outputs mid-cycle, advance the model, step past the edge
  task automatic tick();
    logic        ej, red;
    logic [29:0] tgt;
    @(negedge clk);
    ej  = (cmd_mret_ex | cmd_sret_ex | cmd_uret_ex | jmp_condition_ex) & ~post_trap_m;
    red = cpu_start | trap_ex | ej;
    if (cpu_start)                       tgt = start_adr;
    else if (trap_ex)                    tgt = csr_mtvec_ex;
    else if (cmd_mret_ex & ~post_trap_m) tgt = csr_mepc_ex;
    else if (cmd_sret_ex & ~post_trap_m) tgt = csr_sepc_ex;
    else                                 tgt = jmp_adr_ex;
    chk("post_jump", post_jump_cmd_cond, post_jump_m);
    if (red_prev) chk("pc_data_after_redirect", pc_data, {tgt_prev, 2'b00});
    if (!running_m || i_read_sel || red) chk("ren_blocked", iram_ren, 1'b0);
    if (stall_prev && !red_prev) begin
      chk("stall_valid", inst_valid_id, 1'b1);
      chk("stall_pc", pc_id, prev_pc_id);
      chk("stall_inst", inst_id, prev_inst);
    end
    if (inst_valid_id && inst_ready_id) begin
      chk("pop_pc", pc_id, exp_pc);
      chk("pop_inst", inst_id, mem_f(pc_id[11:0]));
      exp_pc = exp_pc + 30'd1;
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, fetch_m);
    chk("perf_bubble", perf_bubble_cnt, bubble_m);
    if (prev_ren && !red) fetch_m++;
    if (running_m && !inst_valid_id) bubble_m++;
`endif
    stall_prev  = inst_valid_id & ~inst_ready_id;
    prev_pc_id  = pc_id;
    prev_inst   = inst_id;
    red_prev    = red;
    tgt_prev    = tgt;
    post_jump_m = ej;
    post_trap_m = trap_ex;
    running_m   = running_m | cpu_start;
    prev_ren    = iram_ren;
    if (red) exp_pc = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (inst_valid_id) break;
      tick();
    end
    chk(tag, inst_valid_id, 1'b1);
  endtask

  initial begin
    int vcnt;
    logic [29:0] pc_before;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", inst_valid_id, 1'b0);
    chk("rst_inst", inst_id, 32'h0);
    chk("rst_pc_id", pc_id, 30'h0);
    chk("rst_ren", iram_ren, 1'b0);
    chk("rst_post_jump", post_jump_cmd_cond, 1'b0);
    chk("rst_pc_data", pc_data, 32'h0);
    rst_n = 1;
    tick();
    tick();

    // start at 0x10, stream with ready held high
    inst_ready_id = 1;
    cpu_start = 1; start_adr = 30'h10;
    tick();
    cpu_start = 0;
    chk("lat_c1_valid", inst_valid_id, 1'b0);
    tick();
    chk("lat_c2_valid", inst_valid_id, 1'b0);
    tick();
    chk("lat_c3_valid", inst_valid_id, 1'b1);
    chk("lat_c3_pc", pc_id, 30'h10);
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", inst_valid_id, 1'b1);
      tick();
    end

    // backpressure: queue holds exactly QDEPTH entries
    inst_ready_id = 0;
    pc_before = pc_id;
    repeat (10) tick();
    chk("full_ren", iram_ren, 1'b0);
    chk("full_head", pc_id, pc_before);
    i_read_sel = 1; inst_ready_id = 1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (inst_valid_id) vcnt++;
      tick();
    end
    chk("full_entries", vcnt, 4);
    i_read_sel = 0;

    // jump with entries queued
    repeat (4) tick();
    inst_ready_id = 0;
    repeat (3) tick();
    jmp_condition_ex = 1; jmp_adr_ex = 30'h40;
    tick();
    clear_cmds();
    inst_ready_id = 1;
    wait_valid("jmp_wait", 6);
    chk("jmp_pc", pc_id, 30'h40);
    repeat (4) tick();

    // trap followed by jump: jump masked
    trap_ex = 1; csr_mtvec_ex = 30'h200;
    tick();
    clear_cmds();
    jmp_condition_ex = 1; jmp_adr_ex = 30'h300;
    tick();
    clear_cmds();
    chk("trap_mask_pj", post_jump_cmd_cond, 1'b0);
    wait_valid("trap_wait", 6);
    chk("trap_pc", pc_id, 30'h200);
    repeat (4) tick();

    // mret / sret / uret targets
    cmd_mret_ex = 1; csr_mepc_ex = 30'h500; tick(); clear_cmds();
    wait_valid("mret_wait", 6); chk("mret_pc", pc_id, 30'h500);
    cmd_sret_ex = 1; csr_sepc_ex = 30'h600; tick(); clear_cmds();
    wait_valid("sret_wait", 6); chk("sret_pc", pc_id, 30'h600);
    cmd_uret_ex = 1; jmp_adr_ex = 30'h700; tick(); clear_cmds();
    wait_valid("uret_wait", 6); chk("uret_pc", pc_id, 30'h700);
    repeat (4) tick();

    // monitor steal in a steady stream
    i_read_sel = 1;
    repeat (3) tick();
    i_read_sel = 0;
    repeat (8) tick();

    // PC wrap
    cpu_start = 1; start_adr = 30'h3FFFFFFE; tick(); clear_cmds();
    wait_valid("wrap_wait", 6);
    chk("wrap_pc0", pc_id, 30'h3FFFFFFE);
    tick(); tick();
    chk("wrap_pc2", pc_id, 30'h0);
    repeat (4) tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      clear_cmds();
      inst_ready_id = ($urandom_range(0, 9) < 7);
      i_read_sel    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        csr_mtvec_ex = 30'($urandom); csr_mepc_ex = 30'($urandom);
        csr_sepc_ex  = 30'($urandom); jmp_adr_ex  = 30'($urandom);
        start_adr    = 30'($urandom);
        case ($urandom_range(0, 5))
          0: cpu_start = 1;
          1: trap_ex = 1;
          2: cmd_mret_ex = 1;
          3: cmd_sret_ex = 1;
          4: cmd_uret_ex = 1;
          default: begin jmp_condition_ex = 1; trap_ex = ($urandom_range(0, 1) == 1); end
        endcase
      end
      tick();
    end
    clear_cmds();
    inst_ready_id = 1; i_read_sel = 0;
    repeat (6) tick();

    // asynchronous reset mid-operation
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", inst_valid_id, 1'b0);
    chk("midrst_ren", iram_ren, 1'b0);
    chk("midrst_pc_data", pc_data, 32'h0);
    chk("midrst_pj", post_jump_cmd_cond, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("midrst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("midrst_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
    model_reset();
    #1 rst_n = 1;
    repeat (3) tick();
    chk("post_rst_ren", iram_ren, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
